// File: rtl/types_def.sv
// Shared constants and types for the read-return reorder path.
//   read_entries     : number of outstanding reads tracked
//   read_entries_log : width of a read index (log2 of read_entries)
//   read_data_w      : width of returned read data
//   read_resp_t      : back-end response bundle (index + data)
package types_def;

  localparam int read_entries     = 16;
  localparam int read_entries_log = 4;
  localparam int read_data_w      = 16;

  typedef struct packed {
    logic [read_entries_log-1:0] index;
    logic [read_data_w-1:0]      data;
  } read_resp_t;

endpackage

// File: rtl/reorder_data_ram.sv
// Data store for the reorder buffer: one synchronous write port fed by
// back-end responses, one asynchronous read port addressed by the head.
// Ports:
//   clk   : clock
//   we    : write enable (accepted response)
//   waddr : write index (response index)
//   wdata : write data (response data)
//   raddr : read index (head pointer)
//   rdata : data at raddr, combinational
// The array is deliberately left unreset; validity is tracked by the
// fill bits in the parent.
module reorder_data_ram #(
  parameter int ENTRIES = 16,
  parameter int INDEX_W = 4,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               we,
  input  logic [INDEX_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [INDEX_W-1:0] raddr,
  output logic [DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/read_return_reorder.sv
// Read-return reorder buffer. Hands out read indices in issue order,
// accepts back-end read data in any order tagged with those indices, and
// presents data to the requester strictly in issue order.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   alloc_valid  : front end wants an index for a new read
//   alloc_ready  : a slot is free (count < ENTRIES)
//   alloc_index  : index granted on alloc_valid && alloc_ready (tail)
//   resp_valid   : back end returns data
//   resp_index   : index of the returned read
//   resp_data    : returned data
//   out_valid    : head entry allocated and filled
//   out_data     : data of the head entry
//   out_index    : head index
//   out_ready    : requester accepts the head entry
//   count        : outstanding (allocated, not retired) entries
//   err          : sticky flag for responses to unallocated/filled slots
module read_return_reorder
  import types_def::*;
#(
  parameter int ENTRIES = read_entries,
  parameter int INDEX_W = read_entries_log,
  parameter int DATA_W  = read_data_w
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  output logic [INDEX_W-1:0] alloc_index,
  input  logic               resp_valid,
  input  logic [INDEX_W-1:0] resp_index,
  input  logic [DATA_W-1:0]  resp_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [INDEX_W-1:0] out_index,
  input  logic               out_ready,
  output logic [INDEX_W:0]   count,
  output logic               err
);

  localparam logic [INDEX_W:0] FULL_COUNT = (INDEX_W+1)'(ENTRIES);

  logic [INDEX_W-1:0] head_reg, head_next;
  logic [INDEX_W-1:0] tail_reg, tail_next;
  logic [INDEX_W:0]   count_reg, count_next;
  logic [ENTRIES-1:0] alloc_bits_reg, alloc_bits_next;
  logic [ENTRIES-1:0] fill_bits_reg, fill_bits_next;
  logic               err_reg, err_next;

  logic do_alloc;
  logic do_retire;
  logic resp_ok;
  logic resp_bad;

  // Ready depends only on the registered count, so a retire in the same
  // cycle as a full condition does not free a slot until the next cycle.
  assign alloc_ready = (count_reg < FULL_COUNT);
  assign alloc_index = tail_reg;
  assign out_valid   = alloc_bits_reg[head_reg] && fill_bits_reg[head_reg];
  assign out_index   = head_reg;
  assign count       = count_reg;
  assign err         = err_reg;

  assign do_alloc  = alloc_valid && alloc_ready;
  assign do_retire = out_valid && out_ready;

  // A retiring head is already filled, so a response aimed at it lands in
  // the duplicate case below and is dropped.
  assign resp_ok  = resp_valid && alloc_bits_reg[resp_index] && !fill_bits_reg[resp_index];
  assign resp_bad = resp_valid && !resp_ok;

  // Per-entry bit updates. Allocation at tail and retire at head never hit
  // the same slot: that would need the buffer to be both full and empty.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic hit_tail;
    logic hit_head;
    logic hit_resp;
    assign hit_tail = do_alloc  && (tail_reg   == INDEX_W'(gi));
    assign hit_head = do_retire && (head_reg   == INDEX_W'(gi));
    assign hit_resp = resp_ok   && (resp_index == INDEX_W'(gi));

    assign alloc_bits_next[gi] = hit_tail ? 1'b1 :
                                 hit_head ? 1'b0 : alloc_bits_reg[gi];
    assign fill_bits_next[gi]  = (hit_tail || hit_head) ? 1'b0 :
                                 hit_resp ? 1'b1 : fill_bits_reg[gi];
  end

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    err_next   = err_reg || resp_bad;
    if (do_alloc) begin
      tail_next = tail_reg + INDEX_W'(1);
    end
    if (do_retire) begin
      head_next = head_reg + INDEX_W'(1);
    end
    case ({do_alloc, do_retire})
      2'b10:   count_next = count_reg + (INDEX_W+1)'(1);
      2'b01:   count_next = count_reg - (INDEX_W+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      alloc_bits_reg <= '0;
      fill_bits_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      head_reg       <= head_next;
      tail_reg       <= tail_next;
      count_reg      <= count_next;
      alloc_bits_reg <= alloc_bits_next;
      fill_bits_reg  <= fill_bits_next;
      err_reg        <= err_next;
    end
  end

  reorder_data_ram #(
    .ENTRIES(ENTRIES),
    .INDEX_W(INDEX_W),
    .DATA_W (DATA_W)
  ) u_data_ram (
    .clk  (clk),
    .we   (resp_ok),
    .waddr(resp_index),
    .wdata(resp_data),
    .raddr(head_reg),
    .rdata(out_data)
  );

endmodule

// File: tb/tb_read_return_reorder.sv
// Scoreboard bench for read_return_reorder. Stimulus pushes the expected
// in-order (index, data) pair at allocation time; a monitor on the falling
// edge pops and compares whenever an output handshake occurs.
module tb_read_return_reorder;

  localparam int IW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic          alloc_ready;
  logic [IW-1:0] alloc_index;
  logic          resp_valid;
  logic [IW-1:0] resp_index;
  logic [DW-1:0] resp_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic          out_ready;
  logic [IW:0]   count;
  logic          err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [IW-1:0] index;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [IW-1:0] tail_m;

  read_return_reorder dut (
    .clk        (clk),
    .rst        (rst),
    .alloc_valid(alloc_valid),
    .alloc_ready(alloc_ready),
    .alloc_index(alloc_index),
    .resp_valid (resp_valid),
    .resp_index (resp_index),
    .resp_data  (resp_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_ready  (out_ready),
    .count      (count),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: one line per retired transaction.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got idx %0d data 0x%0h, expected nothing", out_index, out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_index", 32'(out_index), 32'(e.index));
        check("out_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    exp_q.delete();
    tail_m = '0;
    cycle();
  endtask

  task automatic alloc(input logic [DW-1:0] exp_data);
    exp_t e;
    check("alloc_ready", 32'(alloc_ready), 32'd1);
    check("alloc_index", 32'(alloc_index), 32'(tail_m));
    e.index = tail_m;
    e.data  = exp_data;
    exp_q.push_back(e);
    tail_m = tail_m + 1'b1;
    alloc_valid = 1'b1;
    cycle();
    alloc_valid = 1'b0;
  endtask

  task automatic respond(input logic [IW-1:0] idx, input logic [DW-1:0] d);
    resp_valid = 1'b1;
    resp_index = idx;
    resp_data  = d;
    cycle();
    resp_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    out_ready = 1'b1;
    while (count != 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0;
    resp_valid = 1'b0;
    resp_index = '0;
    resp_data = '0;
    out_ready = 1'b0;
    tail_m = '0;
    cycle();
    // Reset state while rst is held
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_alloc_index", 32'(alloc_index), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    cycle();

    // In-order fill, then retire on three consecutive cycles
    alloc(16'h00A0);
    alloc(16'h00A1);
    alloc(16'h00A2);
    respond(4'd0, 16'h00A0);
    respond(4'd1, 16'h00A1);
    respond(4'd2, 16'h00A2);
    check("inorder_count", 32'(count), 32'd3);
    out_ready = 1'b1;
    cycle();
    cycle();
    cycle();
    check("inorder_count_after3", 32'(count), 32'd0);
    check("inorder_queue", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;

    // Out-of-order responses
    do_reset();
    out_ready = 1'b1;
    alloc(16'h0000);
    alloc(16'h0011);
    alloc(16'h0022);
    alloc(16'h0033);
    respond(4'd3, 16'h0033);
    check("ooo_valid_after3", 32'(out_valid), 32'd0);
    respond(4'd1, 16'h0011);
    check("ooo_valid_after1", 32'(out_valid), 32'd0);
    respond(4'd2, 16'h0022);
    check("ooo_valid_after2", 32'(out_valid), 32'd0);
    resp_valid = 1'b1;
    resp_index = 4'd0;
    resp_data  = 16'h0000;
    #1;
    check("ooo_no_bypass", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    resp_valid = 1'b0;
    check("ooo_valid_rise", 32'(out_valid), 32'd1);
    drain(10);

    // Full / back-pressure with wrap
    do_reset();
    for (int i = 0; i < 16; i++) alloc(16'h1000 + 16'(i));
    check("full_alloc_ready", 32'(alloc_ready), 32'd0);
    check("full_count", 32'(count), 32'd16);
    alloc_valid = 1'b1;
    cycle();
    alloc_valid = 1'b0;
    check("full_refused_count", 32'(count), 32'd16);
    check("full_refused_index", 32'(alloc_index), 32'd0);
    for (int i = 0; i < 16; i++) respond(4'(i), 16'h1000 + 16'(i));
    check("full_filled_ready", 32'(alloc_ready), 32'd0);
    // Retire one while also requesting an allocation: allocation refused
    out_ready = 1'b1;
    alloc_valid = 1'b1;
    cycle();
    out_ready = 1'b0;
    alloc_valid = 1'b0;
    check("retire1_count", 32'(count), 32'd15);
    check("retire1_alloc_ready", 32'(alloc_ready), 32'd1);
    check("retire1_alloc_index", 32'(alloc_index), 32'd0);
    alloc(16'h2000);
    check("rewrap_count", 32'(count), 32'd16);
    respond(4'd0, 16'h2000);
    drain(40);

    // Stall with data held
    do_reset();
    alloc(16'h005A);
    respond(4'd0, 16'h005A);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'h5A);
      check("stall_index", 32'(out_index), 32'd0);
      check("stall_count", 32'(count), 32'd1);
      cycle();
    end
    drain(5);

    // Response to an unallocated index
    do_reset();
    respond(4'd7, 16'h0077);
    check("unalloc_err", 32'(err), 32'd1);
    check("unalloc_valid", 32'(out_valid), 32'd0);
    check("unalloc_count", 32'(count), 32'd0);

    // Duplicate response keeps original data
    do_reset();
    check("dup_err_clear", 32'(err), 32'd0);
    alloc(16'h00C0);
    alloc(16'h00C1);
    alloc(16'h00C2);
    respond(4'd2, 16'h00C2);
    respond(4'd0, 16'h00C0);
    respond(4'd1, 16'h00C1);
    check("dup_err_before", 32'(err), 32'd0);
    respond(4'd2, 16'h00FF);
    check("dup_err_set", 32'(err), 32'd1);
    drain(10);
    check("dup_err_sticky", 32'(err), 32'd1);

    // Asynchronous reset between edges
    do_reset();
    for (int i = 0; i < 5; i++) alloc(16'h0300 + 16'(i));
    respond(4'd0, 16'h0300);
    respond(4'd1, 16'h0301);
    check("pre_async_count", 32'(count), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_alloc_index", 32'(alloc_index), 32'd0);
    exp_q.delete();
    tail_m = '0;
    cycle();
    rst = 1'b0;
    cycle();
    check("async_err_clear", 32'(err), 32'd0);
    respond(4'd3, 16'h0303);
    check("late_resp_err", 32'(err), 32'd1);
    check("late_resp_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/read_return_reorder.md
Name: read_return_reorder

Overview:
- Return-path counterpart to the front-end request path (mapper -> request_saver -> per-bank FIFOs).
- Hands out in-order read indices when read requests are issued. Accepts read data from the back end in any order, tagged with those indices.
- Delivers data to the requester strictly in issue order.
- Sits between the bank schedulers' read-data return and the controller's requester-side read port.

Parameters:
- ENTRIES, 16, number of outstanding reads; power of two.
- INDEX_W, 4, index width, equal to log2(ENTRIES); matches read_entries_log.
- DATA_W, 16, read data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- alloc_valid  input  1  front end is issuing a read and needs an index.
- alloc_ready  output  1  an index is free (count < ENTRIES).
- alloc_index  output  INDEX_W  index granted when alloc_valid && alloc_ready; equals the tail pointer.
- resp_valid  input  1  back end returns read data.
- resp_index  input  INDEX_W  index of the returned read.
- resp_data  input  DATA_W  returned data.
- out_valid  output  1  in-order data available.
- out_data  output  DATA_W  data of the head entry.
- out_index  output  INDEX_W  head index.
- out_ready  input  1  requester accepts out_data.
- count  output  INDEX_W+1  number of outstanding (allocated, not retired) entries.
- err  output  1  sticky protocol error flag.

Behaviour:
- Reset (async, rst=1): head=0, tail=0, count=0, all alloc_bit=0, all fill_bit=0, err=0.
  - Outputs during reset: alloc_ready=1, alloc_index=0, out_valid=0, out_index=0.
  - out_data is undefined during reset and is ignored while out_valid=0.
  - Data RAM is not reset.
- Allocate: on alloc_valid && alloc_ready: alloc_bit[tail]<=1, fill_bit[tail]<=0, tail<=tail+1 (wraps mod ENTRIES).
  - alloc_valid while full (count=ENTRIES): no state change; alloc_ready=0 is combinational from count.
- Response: on resp_valid: if alloc_bit[resp_index]=1 and fill_bit[resp_index]=0, then data[resp_index]<=resp_data and fill_bit[resp_index]<=1.
  - Response to a non-allocated entry: dropped, err<=1.
  - Duplicate response to an already-filled entry: dropped, data not overwritten, err<=1.
- Output: out_valid = alloc_bit[head] && fill_bit[head], combinational from registers. out_data=data[head]. out_index=head.
  - Latency from a response at index==head to out_valid=1 is 1 cycle; no same-cycle bypass.
- Retire: on out_valid && out_ready: alloc_bit[head]<=0, fill_bit[head]<=0, head<=head+1 (wraps).
  - out_data is held stable while out_valid && !out_ready.
- Count: +1 on allocate, -1 on retire. Both in the same cycle leaves it unchanged. Width INDEX_W+1, range 0..ENTRIES.
- Simultaneous events:
  - Allocate and retire in the same cycle when full: allocation is refused, because alloc_ready is based on the current count. The slot is usable next cycle.
  - Response and retire to different indices in the same cycle: both take effect.
  - A response cannot target head while head is retiring, because head is already filled; such a response counts as a duplicate and sets err.
- Wrap-around: head and tail are INDEX_W bits. Full vs empty is distinguished by count only.
- Reset mid-operation: all outstanding entries are discarded. Back-end responses arriving after reset hit non-allocated entries and set err.
- err clears only on rst.

Decomposition:
- Shared package types_def:
  - read_entries and read_entries_log constants (ENTRIES and INDEX_W default from these).
  - The read-data width constant.
  - A read_resp struct packing index and data, for the back-end interface.
- One sub-module, reorder_data_ram: ENTRIES x DATA_W, single write port (resp), asynchronous read at head.
- Pointers, bit vectors, and count stay in the top module.

Test Plan:
- In-order fill: allocate 0,1,2; respond 0,1,2 with data 0xA0,0xA1,0xA2; out_ready=1 -> out_data 0xA0,0xA1,0xA2 on consecutive cycles, count returns to 0.
- Out-of-order: allocate 0..3; respond 3,1,2 with data 0x33,0x11,0x22 -> out_valid stays 0. Then respond 0 with 0x00 -> 0x00,0x11,0x22,0x33 in order, out_valid rises 1 cycle after the index-0 response.
- Full/back-pressure: allocate 16 with out_ready=0 -> alloc_ready=0, count=16. Respond all, then retire one -> alloc_ready=1 next cycle, next alloc_index=0 (wrap).
- Stall: out_valid=1 with data 0x5A and out_ready held 0 for 5 cycles -> out_data stays 0x5A, head unchanged, count unchanged.
- Errors: respond to unallocated index 7 -> err=1, no out_valid. Duplicate response on a filled index 2 with 0xFF -> original data delivered, err stays 1.
- Async reset mid-run: 5 outstanding, assert rst between clock edges -> count=0, out_valid=0, alloc_index=0 immediately. A late response then sets err=1.
